// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin credit accumulation, per-product stock,
// priced selection, single-cycle vend and change phases. All outputs registered.
module vending_machine_multi #(
    parameter int N_PROD     = 4,
    parameter int VAL_W      = 8,
    parameter int COIN1      = 5,
    parameter int COIN2      = 10,
    parameter int COIN3      = 25,
    parameter logic [N_PROD*VAL_W-1:0] PRICES = {8'd50, 8'd30, 8'd25, 8'd15},
    parameter int MAX_CREDIT = 100,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 2,
    localparam int ID_W      = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        coin,
    input  logic              sel_valid,
    input  logic [ID_W-1:0]   sel_id,
    input  logic              cancel,
    input  logic              restock,
    input  logic [ID_W-1:0]   restock_id,
    output logic              vend,
    output logic [ID_W-1:0]   vend_id,
    output logic              change_valid,
    output logic [VAL_W-1:0]  change,
    output logic [VAL_W-1:0]  credit,
    output logic              coin_reject,
    output logic              sold_out,
    output logic              insufficient,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    localparam logic [VAL_W:0]   MAX_V      = (VAL_W+1)'(MAX_CREDIT);
    localparam logic [VAL_W:0]   COIN1_V    = (VAL_W+1)'(COIN1);
    localparam logic [VAL_W:0]   COIN2_V    = (VAL_W+1)'(COIN2);
    localparam logic [VAL_W:0]   COIN3_V    = (VAL_W+1)'(COIN3);
    localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_INIT);

    state_t             state, state_d;
    logic [VAL_W-1:0]   credit_d;
    logic [ID_W-1:0]    sel_q, sel_d;
    logic [STOCK_W-1:0] stock [N_PROD];
    logic [VAL_W-1:0]   price [N_PROD];

    logic               dec_en;
    logic               sel_ok;
    logic [ID_W-1:0]    sel_idx;
    logic [VAL_W:0]     coin_val;
    logic [VAL_W:0]     credit_sum;

    logic               vend_d;
    logic [ID_W-1:0]    vend_id_d;
    logic               change_valid_d;
    logic [VAL_W-1:0]   change_d;
    logic               coin_reject_d;
    logic               sold_out_d;
    logic               insufficient_d;
    logic               busy_d;

    for (genvar g = 0; g < N_PROD; g++) begin : g_price
        assign price[g] = PRICES[g*VAL_W +: VAL_W];
    end

    always_comb begin
        coin_val = '0;
        case (coin)
            2'd1:    coin_val = COIN1_V;
            2'd2:    coin_val = COIN2_V;
            2'd3:    coin_val = COIN3_V;
            default: coin_val = '0;
        endcase
    end

    assign credit_sum = {1'b0, credit} + coin_val;
    assign sel_ok     = 32'(sel_id) < N_PROD;
    // Out-of-range ids are redirected to slot 0 only to keep array reads in bounds.
    assign sel_idx    = sel_ok ? sel_id : '0;

    always_comb begin
        state_d        = state;
        credit_d       = credit;
        sel_d          = sel_q;
        dec_en         = 1'b0;
        vend_d         = 1'b0;
        vend_id_d      = '0;
        change_valid_d = 1'b0;
        change_d       = '0;
        coin_reject_d  = 1'b0;
        sold_out_d     = 1'b0;
        insufficient_d = 1'b0;

        unique case (state)
            IDLE, COLLECT: begin
                if (cancel) begin
                    coin_reject_d = (coin != 2'd0);
                    if (credit != '0) state_d = CHANGE;
                end else if (sel_valid) begin
                    coin_reject_d = (coin != 2'd0);
                    if (sel_ok) begin
                        if (stock[sel_idx] == '0) begin
                            sold_out_d = 1'b1;
                        end else if (credit < price[sel_idx]) begin
                            insufficient_d = 1'b1;
                        end else begin
                            credit_d = credit - price[sel_idx];
                            dec_en   = 1'b1;
                            sel_d    = sel_idx;
                            state_d  = VEND;
                        end
                    end
                end else if (coin != 2'd0) begin
                    if (credit_sum <= MAX_V) begin
                        credit_d = credit_sum[VAL_W-1:0];
                        state_d  = COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            VEND: begin
                vend_d        = 1'b1;
                vend_id_d     = sel_q;
                coin_reject_d = (coin != 2'd0);
                state_d       = (credit != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                change_valid_d = 1'b1;
                change_d       = credit;
                credit_d       = '0;
                coin_reject_d  = (coin != 2'd0);
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit       <= '0;
            sel_q        <= '0;
            vend         <= 1'b0;
            vend_id      <= '0;
            change_valid <= 1'b0;
            change       <= '0;
            coin_reject  <= 1'b0;
            sold_out     <= 1'b0;
            insufficient <= 1'b0;
            busy         <= 1'b0;
        end else begin
            credit       <= credit_d;
            sel_q        <= sel_d;
            vend         <= vend_d;
            vend_id      <= vend_id_d;
            change_valid <= change_valid_d;
            change       <= change_d;
            coin_reject  <= coin_reject_d;
            sold_out     <= sold_out_d;
            insufficient <= insufficient_d;
            busy         <= busy_d;
        end
    end

    // Restock overrides a same-cycle decrement; decrement is already gated on stock > 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_PROD; i++) stock[i] <= STOCK_FULL;
        end else begin
            for (int unsigned i = 0; i < N_PROD; i++) begin
                if (restock && 32'(restock_id) == i) begin
                    stock[i] <= STOCK_FULL;
                end else if (dec_en && 32'(sel_idx) == i && stock[i] != '0) begin
                    stock[i] <= stock[i] - STOCK_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi: vend ids and change amounts are queued
// at stimulus time and consumed by a monitor when the DUT pulses vend/change_valid.
module tb_vending_machine_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] coin;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       cancel;
    logic       restock;
    logic [1:0] restock_id;
    logic       vend;
    logic [1:0] vend_id;
    logic       change_valid;
    logic [7:0] change;
    logic [7:0] credit;
    logic       coin_reject;
    logic       sold_out;
    logic       insufficient;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int vend_q[$];
    int change_q[$];
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    vending_machine_multi #(
        .N_PROD(4), .VAL_W(8), .COIN1(5), .COIN2(10), .COIN3(25),
        .PRICES({8'd50, 8'd30, 8'd25, 8'd15}),
        .MAX_CREDIT(100), .STOCK_W(4), .STOCK_INIT(2)
    ) dut (
        .clk(clk), .rst(rst), .coin(coin), .sel_valid(sel_valid), .sel_id(sel_id),
        .cancel(cancel), .restock(restock), .restock_id(restock_id),
        .vend(vend), .vend_id(vend_id), .change_valid(change_valid), .change(change),
        .credit(credit), .coin_reject(coin_reject), .sold_out(sold_out),
        .insufficient(insufficient), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Vend/change scoreboard: pop an expectation whenever the DUT produces one.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (vend) begin
                if (vend_q.size() == 0) chk("vend_unexpected", 32'(vend), 0);
                else chk("vend_id", 32'(vend_id), vend_q.pop_front());
            end
            if (change_valid) begin
                if (change_q.size() == 0) chk("change_unexpected", 32'(change_valid), 0);
                else chk("change_amount", 32'(change), change_q.pop_front());
            end else begin
                chk("change_idle_zero", 32'(change), 0);
            end
        end
    end

    task automatic drive(input logic [1:0] c, input logic sv, input logic [1:0] sid,
                         input logic can, input logic rs, input logic [1:0] rid);
        coin = c; sel_valid = sv; sel_id = sid; cancel = can; restock = rs; restock_id = rid;
        @(posedge clk);
        #1;
        coin = 2'd0; sel_valid = 1'b0; sel_id = 2'd0; cancel = 1'b0; restock = 1'b0; restock_id = 2'd0;
    endtask

    task automatic idle();                                drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0); endtask
    task automatic put(input logic [1:0] c);              drive(c,    1'b0, 2'd0, 1'b0, 1'b0, 2'd0); endtask
    task automatic sel(input logic [1:0] id, input logic [1:0] c); drive(c, 1'b1, id, 1'b0, 1'b0, 2'd0); endtask
    task automatic cxl();                                 drive(2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0); endtask
    task automatic rstk(input logic [1:0] id);            drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b1, id);   endtask

    task automatic st(input string tag, input int cr, input bit bz, input bit rej, input bit so, input bit ins);
        chk({tag, "_credit"}, 32'(credit), cr);
        chk({tag, "_busy"}, 32'(busy), 32'(bz));
        chk({tag, "_status"}, 32'({coin_reject, sold_out, insufficient}), 32'({rej, so, ins}));
    endtask

    // 10 + 5 = 15 credit, buy product 0 at price 15: vend with nothing left over.
    task automatic buy0(input string tag);
        put(2'd2);
        put(2'd1);
        st({tag, "_cr15"}, 15, 0, 0, 0, 0);
        vend_q.push_back(0);
        sel(2'd0, 2'd0);
        st({tag, "_sel"}, 0, 1, 0, 0, 0);
        idle();
        st({tag, "_vend"}, 0, 0, 0, 0, 0);
        idle();
    endtask

    initial begin
        rst = 1'b0;
        coin = 2'd0; sel_valid = 1'b0; sel_id = 2'd0; cancel = 1'b0; restock = 1'b0; restock_id = 2'd0;
        #12;
        chk("rst_credit", 32'(credit), 0);
        chk("rst_outputs", 32'({vend, vend_id, change_valid, coin_reject, sold_out, insufficient, busy}), 0);
        chk("rst_change", 32'(change), 0);
        rst = 1'b1;
        mon_en = 1'b1;

        // Coins 10,10 then product 0 (15): vend id 0, change 5.
        put(2'd2); st("a_c1", 10, 0, 0, 0, 0);
        put(2'd2); st("a_c2", 20, 0, 0, 0, 0);
        vend_q.push_back(0);
        change_q.push_back(5);
        sel(2'd0, 2'd0); st("a_sel", 5, 1, 0, 0, 0);
        idle();          st("a_vend", 5, 1, 0, 0, 0);
        idle();          st("a_chg", 0, 0, 0, 0, 0);
        idle();          st("a_idle", 0, 0, 0, 0, 0);

        // Fill to the 100 ceiling, reject the overflow coin, refund everything.
        put(2'd3); st("b_c1", 25, 0, 0, 0, 0);
        put(2'd3); st("b_c2", 50, 0, 0, 0, 0);
        put(2'd3); st("b_c3", 75, 0, 0, 0, 0);
        put(2'd3); st("b_c4", 100, 0, 0, 0, 0);
        put(2'd1); st("b_rej", 100, 0, 1, 0, 0);
        idle();    st("b_hold", 100, 0, 0, 0, 0);
        change_q.push_back(100);
        cxl();     st("b_cxl", 100, 1, 0, 0, 0);
        idle();    st("b_chg", 0, 0, 0, 0, 0);

        // Insufficient credit for product 1 (25), alone and with a coin in the same cycle.
        put(2'd2);       st("c_c1", 10, 0, 0, 0, 0);
        sel(2'd1, 2'd0); st("c_ins", 10, 0, 0, 0, 1);
        sel(2'd1, 2'd3); st("c_ins_rej", 10, 0, 1, 0, 1);
        change_q.push_back(10);
        cxl();           st("c_cxl", 10, 1, 0, 0, 0);
        idle();          st("c_chg", 0, 0, 0, 0, 0);

        // Stock exhaustion on product 0, restock, and restock beating a same-cycle decrement.
        rstk(2'd0); st("d_rs", 0, 0, 0, 0, 0);
        buy0("d1");
        buy0("d2");
        put(2'd2); put(2'd1);
        sel(2'd0, 2'd0); st("d_so", 15, 0, 0, 1, 0);
        rstk(2'd0);      st("d_rs2", 15, 0, 0, 0, 0);
        vend_q.push_back(0);
        drive(2'd0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0); st("d_rs_sel", 0, 1, 0, 0, 0);
        idle(); idle();
        buy0("d3");
        buy0("d4");
        put(2'd2); put(2'd1);
        sel(2'd0, 2'd0); st("d_so2", 15, 0, 0, 1, 0);
        change_q.push_back(15);
        cxl();  st("d_cxl", 15, 1, 0, 0, 0);
        idle(); st("d_chg", 0, 0, 0, 0, 0);

        // Exact price on product 2 (30): no change phase, busy for one cycle, coin rejected in VEND.
        put(2'd3); put(2'd1); st("e_cr30", 30, 0, 0, 0, 0);
        vend_q.push_back(2);
        sel(2'd2, 2'd0); st("e_sel", 0, 1, 0, 0, 0);
        put(2'd1);       st("e_vend", 0, 0, 1, 0, 0);
        idle();          st("e_idle", 0, 0, 0, 0, 0);
        cxl();           st("e_cxl0", 0, 0, 0, 0, 0);
        idle();

        // Asynchronous reset mid-collection: credit dropped, no refund, stocks refilled.
        put(2'd3); st("g_cr25", 25, 0, 0, 0, 0);
        #3 rst = 1'b0;
        #1;
        chk("g_async_credit", 32'(credit), 0);
        chk("g_async_outputs", 32'({vend, change_valid, coin_reject, sold_out, insufficient, busy}), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("g_hold_credit", 32'(credit), 0);
        chk("g_hold_change_valid", 32'(change_valid), 0);
        @(negedge clk) rst = 1'b1;
        buy0("g");

        chk("vend_q_drained", 32'(vend_q.size()), 0);
        chk("change_q_drained", 32'(change_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vending_machine_multi.md
VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

Interface
REQ-001 SHALL have parameter N_PROD, default 4, number of products (1..16).
REQ-002 SHALL have parameter VAL_W, default 8, width of credit, price and change values.
REQ-003 SHALL have parameters COIN1/COIN2/COIN3, defaults 5/10/25, values of coin codes 1/2/3.
REQ-004 SHALL have parameter PRICES, default {8'd50,8'd30,8'd25,8'd15}, N_PROD*VAL_W packed price table; product i uses slice i.
REQ-005 SHALL have parameter MAX_CREDIT, default 100, credit ceiling.
REQ-006 SHALL have parameters STOCK_W, default 4, and STOCK_INIT, default 2, per-product stock width and reset/restock fill level.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port coin, input, 2 bits: 0 none, 1..3 = COIN1..COIN3, sampled each cycle.
REQ-010 SHALL have ports sel_valid (1 bit) and sel_id ($clog2(N_PROD) bits), inputs, product selection request.
REQ-011 SHALL have port cancel, input, 1 bit, refund request.
REQ-012 SHALL have ports restock (1 bit) and restock_id ($clog2(N_PROD) bits), inputs.
REQ-013 SHALL have ports vend (1 bit) and vend_id ($clog2(N_PROD) bits), outputs, dispense pulse and product.
REQ-014 SHALL have ports change_valid (1 bit) and change (VAL_W bits), outputs, refund pulse and amount.
REQ-015 SHALL have port credit, output, VAL_W bits, current accumulated credit.
REQ-016 SHALL have ports coin_reject, sold_out, insufficient, outputs, 1 bit each, one-cycle status pulses.
REQ-017 SHALL have port busy, output, 1 bit, high in VEND and CHANGE states.

Function
REQ-018 SHALL implement FSM states IDLE, COLLECT, VEND, CHANGE; all outputs registered.
REQ-019 IDLE/COLLECT: valid coin with credit+value <= MAX_CREDIT SHALL add value to credit next cycle and enter/stay COLLECT.
REQ-020 Coin that would exceed MAX_CREDIT SHALL be rejected: coin_reject=1 one cycle, credit unchanged.
REQ-021 Per-cycle priority in IDLE/COLLECT SHALL be cancel > sel_valid > coin; a coin arriving with cancel or sel_valid SHALL be rejected (coin_reject=1).
REQ-022 cancel with credit>0 SHALL enter CHANGE; cancel with credit=0 SHALL be ignored, stay IDLE.
REQ-023 sel_valid with sel_id >= N_PROD SHALL be ignored.
REQ-024 sel_valid on product with stock 0 SHALL pulse sold_out, state and credit unchanged.
REQ-025 sel_valid with stock>0 and credit < price SHALL pulse insufficient, state and credit unchanged.
REQ-026 sel_valid with stock>0 and credit >= price SHALL set credit=credit-price, decrement that stock, enter VEND.
REQ-027 VEND SHALL last exactly one cycle with vend=1, vend_id=selected product; next state CHANGE if credit>0 else IDLE.
REQ-028 CHANGE SHALL last exactly one cycle with change_valid=1, change=credit; credit SHALL be 0 on the following cycle; next state IDLE.
REQ-029 change SHALL be 0 whenever change_valid=0.
REQ-030 In VEND/CHANGE, coin inputs SHALL be rejected (coin_reject=1), sel_valid and cancel ignored.
REQ-031 Latency: sel_valid accepted at edge N -> vend=1 after edge N+1 -> change_valid=1 after edge N+2 if credit remains.
REQ-032 restock SHALL set stock[restock_id] to STOCK_INIT in any state; restock and decrement of same product in one cycle -> restock wins.
REQ-033 Stock counters SHALL never wrap below 0 or above STOCK_INIT.

Reset
REQ-034 rst=0 SHALL immediately force IDLE, credit=0, all pulses/vend/vend_id/change_valid/change/busy=0, every stock=STOCK_INIT.
REQ-035 Reset mid-transaction SHALL discard credit without change_valid.

Verification (defaults)
REQ-036 Coins 10,10 then sel 0 -> credit 20, vend=1 vend_id=0, then change_valid=1 change=5, then IDLE credit 0.
REQ-037 Coins 25,25,25,25 then coin 5 -> credit 100, coin_reject=1, credit stays 100; cancel -> change=100.
REQ-038 Credit 10, sel 1 -> insufficient=1, credit 10; sel 1 with coin=3 same cycle -> insufficient=1 and coin_reject=1, credit 10.
REQ-039 Buy product 0 twice (credit 15 each) -> two vends, no change; third sel 0 with credit 15 -> sold_out=1; restock id 0 then sel 0 -> vend.
REQ-040 Credit 25, assert rst low between edges -> outputs and credit 0 asynchronously, no change_valid, stocks back to 2.
REQ-041 Credit 30, sel 2 -> vend, no CHANGE state (change_valid stays 0), busy high exactly one cycle.
